id_ex_hazard_ctrl: RTL

//  Control-side consumer of the ID/EX pipeline register. Reads ID/EX outputs plus ID-stage source regs,

---
 rtl/id_ex_hazard_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_hazard_ctrl
// Purpose  : Hazard control that sits beside the ID/EX pipeline register.
//            It shadows the EX destination down through MEM and WB, produces
//            the EX-stage ALU operand forwarding selects, detects load-use
//            hazards (stall + bubble) and drives taken-branch flushes.
//            Saturating counters record stall cycles and branch flush events.
// Ports    :
//   clk, rst           clock / synchronous active-high reset
//   ReadRegister1/2    rs/rt of the instruction in ID
//   MemRead_EX         EX instruction is a load
//   RegWrite_EX        EX instruction writes a register
//   RegDest_EX         00 rt, 01 rd, 10 $31, 11 no destination
//   Instruction_EX     EX instruction word (rt/rd fields used)
//   ReadRegister1/2_EX rs/rt of the instruction in EX
//   BranchTaken_EX     branch in EX resolved taken
//   Stall_IF_ID        hold PC and IF/ID
//   Bubble_ID_EX       zero control into ID/EX at next edge
//   Flush_IF_ID        zero IF/ID at next edge
//   ForwardA/B_EX      00 regfile, 01 WB result, 10 MEM ALU result
//   WriteReg_MEM/WB    shadowed destination registers
//   StallCount         saturating load-use stall count
//   FlushCount         saturating taken-branch count
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  input  logic             MemRead_EX,
  input  logic             RegWrite_EX,
  input  logic [1:0]       RegDest_EX,
  input  logic [31:0]      Instruction_EX,
  input  logic [4:0]       ReadRegister1_EX,
  input  logic [4:0]       ReadRegister2_EX,
  input  logic             BranchTaken_EX,
  output logic             Stall_IF_ID,
  output logic             Bubble_ID_EX,
  output logic             Flush_IF_ID,
  output logic [1:0]       ForwardA_EX,
  output logic [1:0]       ForwardB_EX,
  output logic [4:0]       WriteReg_MEM,
  output logic [4:0]       WriteReg_WB,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [3:0] c_FCNT_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic       c_MULTI     = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_fcnt;
  logic [3:0] w_fcnt_nxt;

  logic [4:0] w_dest_ex;
  logic       w_wr_ex;
  logic       w_load_use;
  logic       w_inc_stall;
  logic       w_inc_flush;

  logic [4:0] r_reg_mem;
  logic       r_rw_mem;
  logic       r_mr_mem;
  logic [4:0] r_reg_wb;
  logic       r_rw_wb;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Only the rt/rd fields of the EX instruction are relevant here.
  logic w_unused_inst;
  assign w_unused_inst = ^{Instruction_EX[31:21], Instruction_EX[10:0]};

  // Destination decode. "No destination" is carried as register 0 so that
  // the shadowed WriteReg never aliases a real register.
  always_comb begin
    w_dest_ex = 5'd0;
    case (RegDest_EX)
      2'b00:   w_dest_ex = Instruction_EX[20:16];
      2'b01:   w_dest_ex = Instruction_EX[15:11];
      2'b10:   w_dest_ex = 5'd31;
      default: w_dest_ex = 5'd0;
    endcase
  end

  assign w_wr_ex = RegWrite_EX && (w_dest_ex != 5'd0);

  // Shadow pipe: advances every edge; bubbles arrive through the EX inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_mem <= 5'd0;
      r_rw_mem  <= 1'b0;
      r_mr_mem  <= 1'b0;
      r_reg_wb  <= 5'd0;
      r_rw_wb   <= 1'b0;
    end else begin
      r_reg_mem <= w_dest_ex;
      r_rw_mem  <= w_wr_ex;
      r_mr_mem  <= MemRead_EX;
      r_reg_wb  <= r_reg_mem;
      r_rw_wb   <= r_rw_mem;
    end
  end

  assign WriteReg_MEM = r_reg_mem;
  assign WriteReg_WB  = r_reg_wb;

  // Forwarding. MEM is the younger producer so it wins; a load sitting in
  // MEM has no data yet, but the load-use stall ensures it is in WB by then.
  always_comb begin
    ForwardA_EX = 2'b00;
    ForwardB_EX = 2'b00;
    if (r_rw_mem && (r_reg_mem != 5'd0) && (r_reg_mem == ReadRegister1_EX) && !r_mr_mem)
      ForwardA_EX = 2'b10;
    else if (r_rw_wb && (r_reg_wb != 5'd0) && (r_reg_wb == ReadRegister1_EX))
      ForwardA_EX = 2'b01;
    if (r_rw_mem && (r_reg_mem != 5'd0) && (r_reg_mem == ReadRegister2_EX) && !r_mr_mem)
      ForwardB_EX = 2'b10;
    else if (r_rw_wb && (r_reg_wb != 5'd0) && (r_reg_wb == ReadRegister2_EX))
      ForwardB_EX = 2'b01;
  end

  assign w_load_use = MemRead_EX && w_wr_ex &&
                      ((w_dest_ex == ReadRegister1) || (w_dest_ex == ReadRegister2));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_fcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_fcnt_nxt   = r_fcnt;
    Stall_IF_ID  = 1'b0;
    Bubble_ID_EX = 1'b0;
    Flush_IF_ID  = 1'b0;
    w_inc_stall  = 1'b0;
    w_inc_flush  = 1'b0;
    case (r_state)
      S_RUN: begin
        // A taken branch discards the ID instruction, so its load-use
        // hazard is moot and no stall is charged.
        if (BranchTaken_EX) begin
          Flush_IF_ID  = 1'b1;
          Bubble_ID_EX = 1'b1;
          w_inc_flush  = 1'b1;
          if (c_MULTI) begin
            w_state_nxt = S_FLUSH;
            w_fcnt_nxt  = c_FCNT_INIT;
          end
        end else if (w_load_use) begin
          Stall_IF_ID  = 1'b1;
          Bubble_ID_EX = 1'b1;
          w_inc_stall  = 1'b1;
          w_state_nxt  = S_STALL;
        end
      end
      S_STALL: begin
        // Bubble now in EX and the load in MEM; one cycle clears the hazard.
        w_state_nxt = S_RUN;
      end
      S_FLUSH: begin
        Flush_IF_ID  = 1'b1;
        Bubble_ID_EX = 1'b1;
        w_fcnt_nxt   = r_fcnt - 4'd1;
        if (r_fcnt <= 4'd1) begin
          w_state_nxt = S_RUN;
          w_fcnt_nxt  = 4'd0;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_fcnt_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_inc_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_inc_flush && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule
`default_nettype wire
